// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    HI   = 3'd2,
    LO   = 3'd3,
    CHK  = 3'd4,
    FILL = 3'd5,
    DONE = 3'd6,
    ERR  = 3'd7
  } state_t;

  localparam int         BYTES_PER_WORD = 2;
  localparam logic [7:0] CHK_OK         = 8'h00;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
interface prog_loader_if #(
  parameter int PC_WIDTH = 8,
  parameter int IR_WIDTH = 16
) ();

  // Byte handshake: a byte moves on a rising clk edge where byte_valid and
  // byte_ready are both high; a source seeing byte_ready low holds its byte.
  logic                byte_valid;
  logic [7:0]          byte_data;
  logic                byte_ready;
  logic                wr_en;
  logic [PC_WIDTH-1:0] wr_addr;
  logic [IR_WIDTH-1:0] wr_data;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/prog_loader.sv
// Loads a LEN/data/CHK byte stream into program memory, zero-fills the rest,
// and holds the core stalled until a checksum-valid image is in place.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int PC_WIDTH = 8,
  parameter int IR_WIDTH = 16,
  parameter int CMD_CNT  = 64
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  prog_loader_if.master bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output state_t        dbg_state
);

  localparam logic [8:0]          LEN_MAX  = 9'(CMD_CNT);
  localparam logic [PC_WIDTH-1:0] LAST_ADR = PC_WIDTH'(CMD_CNT - 1);

  state_t              r_state;
  state_t              w_next;
  logic [PC_WIDTH-1:0] r_cnt;
  logic [7:0]          r_sum;
  logic [7:0]          r_len;
  logic [7:0]          r_hi;
  logic                r_lo_wr;
  logic [PC_WIDTH-1:0] r_wr_addr;
  logic [IR_WIDTH-1:0] r_wr_data;

  logic                w_byte_ready;
  logic                w_accept;
  logic [7:0]          w_sum_nxt;
  logic                w_len_bad;
  logic                w_len_full;
  logic                w_last_word;
  logic                w_fill_last;
  logic [8:0]          w_cnt_inc;

  assign w_accept    = bus.byte_valid && w_byte_ready;
  assign w_sum_nxt   = r_sum + bus.byte_data;
  assign w_len_bad   = (bus.byte_data == 8'd0) || ({1'b0, bus.byte_data} > LEN_MAX);
  assign w_len_full  = ({1'b0, r_len} == LEN_MAX);
  assign w_cnt_inc   = 9'(r_cnt) + 9'd1;
  assign w_last_word = (w_cnt_inc == {1'b0, r_len});
  assign w_fill_last = (r_cnt == LAST_ADR);

  // State register and datapath
  always_ff @(posedge clk) begin
    if (res) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_len     <= '0;
      r_hi      <= '0;
      r_lo_wr   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      r_lo_wr <= 1'b0;
      case (r_state)
        IDLE, ERR: begin
          if (start) begin
            r_cnt <= '0;
            r_sum <= '0;
          end
        end
        LEN: begin
          if (w_accept && !w_len_bad) begin
            r_len <= bus.byte_data;
            r_sum <= w_sum_nxt;
          end
        end
        HI: begin
          if (w_accept) begin
            r_hi  <= bus.byte_data;
            r_sum <= w_sum_nxt;
          end
        end
        LO: begin
          // The word is written the cycle after the low byte lands.
          if (w_accept) begin
            r_sum     <= w_sum_nxt;
            r_lo_wr   <= 1'b1;
            r_wr_addr <= r_cnt;
            r_wr_data <= IR_WIDTH'({r_hi, bus.byte_data});
            r_cnt     <= r_cnt + 1'b1;
          end
        end
        CHK: begin
          if (w_accept) r_sum <= w_sum_nxt;
        end
        FILL: begin
          if (!w_fill_last) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = LEN;
      LEN:  if (w_accept) w_next = w_len_bad ? ERR : HI;
      HI:   if (w_accept) w_next = LO;
      LO:   if (w_accept) w_next = w_last_word ? CHK : HI;
      CHK: begin
        if (w_accept) begin
          if (w_sum_nxt != CHK_OK) w_next = ERR;
          else if (w_len_full)     w_next = DONE;
          else                     w_next = FILL;
        end
      end
      FILL: if (w_fill_last) w_next = DONE;
      DONE: w_next = IDLE;
      ERR:  if (start) w_next = LEN;
      default: w_next = IDLE;
    endcase
  end

  // Outputs; byte_ready drops while a data word is being written
  always_comb begin
    w_byte_ready = 1'b0;
    bus.wr_en    = r_lo_wr;
    bus.wr_addr  = r_wr_addr;
    bus.wr_data  = r_wr_data;
    cpu_hold     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (r_state)
      LEN, HI, LO, CHK: begin
        w_byte_ready = !r_lo_wr;
        cpu_hold     = 1'b1;
        busy         = 1'b1;
      end
      FILL: begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = r_cnt;
        bus.wr_data = '0;
        cpu_hold    = 1'b1;
        busy        = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      ERR: begin
        cpu_hold = 1'b1;
        err      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.byte_ready = w_byte_ready;
  assign dbg_state      = r_state;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Write-side counterpart of the program memory: receives a program image as a byte stream and writes it word by word into program memory through its write port.
- Zero-fills every address not covered by the image, then validates an 8-bit checksum.
- Holds the CPU core stalled (cpu_hold) from start until a successful load completes.
- Sits between the host/debug byte source and the program memory write port.

Parameters:
- PC_WIDTH, 8, width of the program-memory address.
- IR_WIDTH, 16, instruction word width; fixed at 2 bytes per word.
- CMD_CNT, 64, number of program-memory words; must be ≤ 2^PC_WIDTH and ≤ 255.

Ports:
- clk  in  1  clock; all logic on rising edge.
- res  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse that begins a load; ignored unless the FSM is in IDLE or ERR.
- byte_valid  in  1  byte_data is valid this cycle.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle. A byte is consumed when byte_valid and byte_ready are both high at a clk edge.
- wr_en  out  1  program-memory write strobe, one cycle per word.
- wr_addr  out  PC_WIDTH  write address.
- wr_data  out  IR_WIDTH  write data.
- cpu_hold  out  1  stall/reset request to the core.
- busy  out  1  FSM is not in IDLE and not in ERR.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error flag.

Behaviour:
- Reset (res=1 at edge): FSM→IDLE. byte_ready, wr_en, cpu_hold, busy, done, err = 0. wr_addr, wr_data = 0. Word counter and checksum accumulator = 0. Reset mid-load abandons the load immediately; memory is left partially written.
- Stream format: LEN byte (word count N), then N words sent high byte first, then a CHK byte. The load is valid when the 8-bit sum of LEN, all data bytes and CHK equals 0x00 (mod 256).
- FSM states:
  - IDLE: on start → LEN. Set cpu_hold=1, clear err, clear accumulator and address counter.
  - LEN: byte_ready=1. On accept: if N==0 or N>CMD_CNT → ERR; otherwise latch N, add the byte to the sum, → HI.
  - HI: byte_ready=1. On accept: latch the high byte, add it to the sum, → LO.
  - LO: byte_ready=1. On accept: add the byte to the sum. The next cycle drives wr_en=1, wr_addr=counter, wr_data={hi,lo}, then increments the counter. If counter+1==N → CHK, else → HI. Write latency is exactly 1 cycle after the LO byte is accepted.
  - CHK: byte_ready=1. On accept: if the final sum is 0 → FILL (or → DONE if N==CMD_CNT); otherwise → ERR.
  - FILL: byte_ready=0. Writes wr_data=0 to addresses N..CMD_CNT-1, one per cycle with wr_en=1. After the write to CMD_CNT-1 → DONE.
  - DONE: done=1 for exactly 1 cycle, cpu_hold→0, then → IDLE.
  - ERR: err=1, cpu_hold remains 1, byte_ready=0. Exits only on start (→ LEN, err cleared) or res.
- Byte acceptance: byte_ready=0 in the cycle wr_en is asserted from LO, so at most one byte per 2 cycles during data. byte_valid with byte_ready=0 is not consumed; the source must hold the byte.
- start while busy is ignored.
- Widths: the address counter is PC_WIDTH wide and never wraps; FILL terminates at CMD_CNT-1. The sum is 8 bits and wraps.
- busy=1 in LEN, HI, LO, CHK, FILL and DONE.

Decomposition:
- Shared package holds: the state enum (IDLE, LEN, HI, LO, CHK, FILL, DONE, ERR), the BYTES_PER_WORD=2 constant, and the CHK_OK=8'h00 constant.
- Single module; no sub-module needed. A checksum accumulator is too small to justify separation.

Test Plan:
1. Nominal load: start; stream 02 49 03 4A 14 54 → writes (0,0x4903), (1,0x4A14), then zero writes to 2..63 (62 cycles). Then done pulses once, cpu_hold falls, err=0.
2. Bad checksum: same stream with CHK=55 → no FILL writes, err=1, cpu_hold stays 1, busy=0. A subsequent start with the correct stream succeeds and clears err.
3. Length boundaries: LEN=00 → ERR immediately with no wr_en. LEN=41 (65) → ERR. LEN=40 (64) with valid data/CHK → 64 writes, no FILL, done.
4. Backpressure/stalls: byte_valid toggled randomly during stream 01 12 34 B9 → exactly one write (0,0x1234). No byte is duplicated or dropped; wr_en appears 1 cycle after the LO byte is accepted.
5. Reset mid-load: assert res after the HI byte → all outputs 0, FSM IDLE. Next start + stream 01 00 01 FE loads (0,0x0001) and completes.
6. start while busy: pulse start during FILL → ignored; FILL completes and done pulses once.
